apb_master: RTL and testbench

- APB requester that turns a simple valid/ready command port into AMBA APB transfers (SETUP then ACCESS) and returns one response per command.
- Sits between a test or CPU-side command source and the APB bus that feeds APB slaves such as the UART register block.
- Single outstanding transfer.
- Optional PREADY watchdog, so a stalled slave cannot hang the bus.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_master.sv | 126 ++++++++++++
 tb/tb_apb_master.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state encoding and transfer-direction constants for the APB requester
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam logic APB_WRITE = 1'b1;
    localparam logic APB_READ  = 1'b0;

endpackage

// File: rtl/apb_master.sv
// rtl/apb_master.sv - valid/ready command port to APB SETUP/ACCESS transfers, one response per command
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PSLVERR
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    apb_state_e            state_q, state_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q       <= ST_IDLE;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wait_cnt_d    = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    pwrite_d   = cmd_write;
                    paddr_d    = cmd_addr;
                    pwdata_d   = cmd_wdata;
                    wait_cnt_d = '0;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                wait_cnt_d = '0;
                state_d    = ST_ACCESS;
            end
            ST_ACCESS: begin
                // PREADY wins over the watchdog in the final permitted cycle
                if (PREADY) begin
                    rsp_rdata_d   = (pwrite_q == APB_WRITE) ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if ((TIMEOUT != 0) && (wait_cnt_q == LAST_WAIT)) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end else if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus and handshake strobes decode straight from state so reset clears them without a clock
    assign PSELx       = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PENABLE     = (state_q == ST_ACCESS);
    assign rsp_valid   = (state_q == ST_RESP);
    assign cmd_ready   = (state_q == ST_IDLE) && !PRESET;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - scoreboard bench for apb_master with a scripted APB slave
module tb_apb_master;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          PSELx;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic          PREADY = 1'b0;
    logic [DW-1:0] PRDATA = '0;
    logic          PSLVERR = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
        int            hs;
        int            lat;
    } exp_t;
    exp_t sb[$];

    logic          cur_write = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_wdata = '0;

    int            sl_wait = 0;
    logic [DW-1:0] sl_rdata = '0;
    logic          sl_err = 1'b0;

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Slave: PREADY rises in ACCESS cycle index sl_wait; PSLVERR is junk-high while waiting
    initial begin
        int acc_n;
        acc_n = 0;
        forever begin
            @(negedge PCLK);
            if (PSELx && PENABLE) begin
                PREADY  = (acc_n == sl_wait);
                PSLVERR = PREADY ? sl_err : 1'b1;
                PRDATA  = sl_rdata;
                acc_n++;
            end else begin
                acc_n   = 0;
                PREADY  = 1'b0;
                PSLVERR = 1'b0;
            end
        end
    end

    // Monitor: bus-phase invariants plus scoreboard pop on each accepted response
    initial begin
        logic prev_v;
        int   first_cyc;
        exp_t e;
        prev_v = 1'b0;
        first_cyc = 0;
        forever begin
            @(negedge PCLK);
            if (PRESET) begin
                prev_v = 1'b0;
            end else begin
                chk("penable_without_psel", PENABLE & ~PSELx, 0);
                if (PSELx) begin
                    chk("paddr", PADDR, cur_addr);
                    chk("pwdata", PWDATA, cur_wdata);
                    chk("pwrite", PWRITE, cur_write);
                end
                if (rsp_valid && !prev_v) first_cyc = cyc;
                prev_v = rsp_valid;
                if (rsp_valid && rsp_ready) begin
                    chk("rsp_expected", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_err", rsp_err, e.err);
                        chk("rsp_timeout", rsp_timeout, e.tmo);
                        chk("rsp_latency", first_cyc - e.hs, e.lat);
                        chk("psel_in_resp", PSELx | PENABLE, 0);
                    end
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] er, input logic ee, input logic et,
                         input int lat, input bit push);
        int   n;
        exp_t e;
        cur_write = w;
        cur_addr  = a;
        cur_wdata = d;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        n = 0;
        @(negedge PCLK);
        while (!cmd_ready && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        chk("cmd_accept", cmd_ready, 1);
        e.rdata = er;
        e.err   = ee;
        e.tmo   = et;
        e.hs    = cyc;
        e.lat   = lat;
        if (push) sb.push_back(e);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        exp_t e;

        tick(); tick(); tick();
        chk("rst_psel", PSELx, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        PRESET = 1'b0;
        tick();
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // zero-wait write; PRDATA carries junk that must not leak into the response
        sl_wait = 0; sl_rdata = 16'hDEAD; sl_err = 1'b0;
        issue(1'b1, 4'h2, 16'hA55A, 16'h0000, 1'b0, 1'b0, 3, 1'b1);
        chk("wr_setup_psel", PSELx, 1);
        chk("wr_setup_penable", PENABLE, 0);
        chk("wr_setup_cmd_ready", cmd_ready, 0);
        tick();
        chk("wr_access_psel", PSELx, 1);
        chk("wr_access_penable", PENABLE, 1);
        drain();

        sl_wait = 3; sl_rdata = 16'h1234; sl_err = 1'b0;
        issue(1'b0, 4'h6, 16'h0000, 16'h1234, 1'b0, 1'b0, 6, 1'b1);
        drain();

        sl_wait = 1; sl_rdata = 16'h0BAD; sl_err = 1'b1;
        issue(1'b0, 4'hF, 16'h0000, 16'h0BAD, 1'b1, 1'b0, 4, 1'b1);
        drain();

        sl_wait = 0; sl_rdata = 16'hFFFF; sl_err = 1'b1;
        issue(1'b1, 4'h1, 16'h0001, 16'h0000, 1'b1, 1'b0, 3, 1'b1);
        drain();

        sl_wait = 1000; sl_rdata = 16'h7777; sl_err = 1'b0;
        issue(1'b0, 4'h5, 16'h0000, 16'h0000, 1'b1, 1'b1, 18, 1'b1);
        drain();

        sl_wait = 15; sl_rdata = 16'h7E57; sl_err = 1'b0;
        issue(1'b0, 4'h5, 16'h0000, 16'h7E57, 1'b0, 1'b0, 18, 1'b1);
        drain();

        // response backpressure with a second command held on the port
        sl_wait = 0; sl_rdata = 16'h0099; sl_err = 1'b0;
        rsp_ready = 1'b0;
        issue(1'b0, 4'h9, 16'h0000, 16'h0099, 1'b0, 1'b0, 3, 1'b1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("bp_rsp_valid", rsp_valid, 1);
        cur_write = 1'b1; cur_addr = 4'h3; cur_wdata = 16'hBEEF;
        cmd_write = 1'b1; cmd_addr = 4'h3; cmd_wdata = 16'hBEEF; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rdata_stable", rsp_rdata, 16'h0099);
            chk("bp_err_stable", rsp_err, 0);
            chk("bp_valid_held", rsp_valid, 1);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_no_setup", PSELx, 0);
            tick();
        end
        k = cyc;
        rsp_ready = 1'b1;
        e.rdata = 16'h0000; e.err = 1'b0; e.tmo = 1'b0; e.hs = k + 1; e.lat = 3;
        sb.push_back(e);
        tick();
        chk("bp_idle_cmd_ready", cmd_ready, 1);
        chk("bp_idle_psel", PSELx, 0);
        tick();
        cmd_valid = 1'b0;
        chk("bp_setup_psel", PSELx, 1);
        chk("bp_setup_penable", PENABLE, 0);
        drain();

        // reset while the slave is stalling in ACCESS
        sl_wait = 1000; sl_rdata = 16'h5555; sl_err = 1'b0;
        issue(1'b0, 4'h7, 16'h0000, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
        tick(); tick(); tick();
        chk("pre_rst_penable", PENABLE, 1);
        #2;
        PRESET = 1'b1;
        #1;
        chk("async_rst_psel", PSELx, 0);
        chk("async_rst_penable", PENABLE, 0);
        chk("async_rst_rsp_valid", rsp_valid, 0);
        tick(); tick();
        PRESET = 1'b0;
        tick();
        chk("rerst_cmd_ready", cmd_ready, 1);
        for (int i = 0; i < 25; i++) tick();
        chk("no_stale_rsp", rsp_valid, 0);

        sl_wait = 0; sl_rdata = 16'h0000; sl_err = 1'b0;
        issue(1'b1, 4'h4, 16'h1111, 16'h0000, 1'b0, 1'b0, 3, 1'b1);
        drain();
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
